// File: rtl/mux_tree_pipe.sv
// Pipelined N_IN:1 word multiplexer tree with valid/ready handshake and a global stall.
// Define MUX_TREE_PIPE_SEL_ERR_EN to add the err output that flags out-of-range selects.
`timescale 1ns/1ps

module mux_tree_pipe #(
    parameter  int N_IN   = 8,
    parameter  int DW     = 8,
    localparam int SELW   = $clog2(N_IN),
    localparam int LEVELS = $clog2(N_IN)
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic [N_IN*DW-1:0] i,
    input  logic [SELW-1:0]    sel,
    input  logic               in_valid,
    output logic               in_ready,
    output logic [DW-1:0]      z,
    output logic               out_valid,
    input  logic               out_ready
`ifdef MUX_TREE_PIPE_SEL_ERR_EN
    ,
    output logic               err
`endif
);

    // Number of words left after the given tree level (level 0 is the raw input).
    function automatic int words_at(input int lvl);
        return (N_IN + (1 << lvl) - 1) >> lvl;
    endfunction

    logic                    advance;
    logic                    sel_oor;
    logic [N_IN-1:0][DW-1:0] words0;

    assign advance  = out_ready | ~out_valid;
    assign in_ready = advance;
    assign sel_oor  = {1'b0, sel} >= (SELW + 1)'(N_IN);

    // Zeroing every leaf on an out-of-range select makes the tree itself produce 0.
    always_comb begin
        for (int k = 0; k < N_IN; k++) begin
            words0[k] = sel_oor ? '0 : i[k*DW +: DW];
        end
    end

    for (genvar l = 1; l <= LEVELS; l++) begin : g_lvl
        localparam int CIN  = words_at(l - 1);
        localparam int COUT = words_at(l);
        localparam int SW   = SELW - l + 1;

        logic                    v_in;
        logic [SW-1:0]           s_in;
        logic [CIN-1:0][DW-1:0]  d_in;
        logic [COUT-1:0][DW-1:0] d_red;
        logic                    v_q;
        logic [COUT-1:0][DW-1:0] d_q;

        if (l == 1) begin : g_src
            assign v_in = in_valid;
            assign s_in = sel;
            assign d_in = words0;
        end else begin : g_src
            assign v_in = g_lvl[l-1].v_q;
            assign s_in = g_lvl[l-1].g_sq.s_q;
            assign d_in = g_lvl[l-1].d_q;
        end

        // An unpaired last word passes straight through to the next level.
        for (genvar m = 0; m < COUT; m++) begin : g_node
            if (2*m + 1 < CIN) begin : g_pair
                assign d_red[m] = s_in[0] ? d_in[2*m+1] : d_in[2*m];
            end else begin : g_pass
                assign d_red[m] = d_in[2*m];
            end
        end

        // NOTE: state is written with non-blocking assignments so every stage
        // samples its predecessor's pre-edge value and the pipeline shifts by one.
        // NOTE: the data registers are reset as well, so nothing from before a
        // reset can ever reach z, even through the output gating.
        always_ff @(posedge clk or negedge rst_n) begin
            if (!rst_n) begin
                v_q <= 1'b0;
                d_q <= '0;
            end else if (advance) begin
                v_q <= v_in;
                d_q <= d_red;
            end
        end

        if (l < LEVELS) begin : g_sq
            logic [SW-2:0] s_q;

            always_ff @(posedge clk or negedge rst_n) begin
                if (!rst_n) begin
                    s_q <= '0;
                end else if (advance) begin
                    s_q <= s_in[SW-1:1];
                end
            end
        end

`ifdef MUX_TREE_PIPE_SEL_ERR_EN
        logic e_in;
        logic e_q;

        if (l == 1) begin : g_esrc
            assign e_in = sel_oor;
        end else begin : g_esrc
            assign e_in = g_lvl[l-1].e_q;
        end

        always_ff @(posedge clk or negedge rst_n) begin
            if (!rst_n) begin
                e_q <= 1'b0;
            end else if (advance) begin
                e_q <= e_in;
            end
        end
`endif
    end

    assign out_valid = g_lvl[LEVELS].v_q;
    assign z         = out_valid ? g_lvl[LEVELS].d_q[0] : '0;

`ifdef MUX_TREE_PIPE_SEL_ERR_EN
    assign err = out_valid & g_lvl[LEVELS].e_q;
`endif

endmodule

// File: tb/tb_mux_tree_pipe.sv
// Scoreboard bench for mux_tree_pipe: three sizes (8x8, 5x4, 2x1) checked against a word-select model.
// err is checked only when MUX_TREE_PIPE_SEL_ERR_EN is defined.
`timescale 1ns/1ps

module tb_mux_tree_pipe;

    localparam int N8 = 8, DW8 = 8, LV8 = 3;
    localparam int N5 = 5, DW5 = 4, LV5 = 3;
    localparam int N2 = 2, DW2 = 1, LV2 = 1;

    typedef struct {
        logic [7:0] data;
        logic       err;
        int         acc;
        bit         lat;
    } exp_t;

    logic clk = 1'b0;
    logic rst_n;
    int   cyc = 0;

    logic [63:0] a_i;
    logic [2:0]  a_sel;
    logic        a_in_valid, a_in_ready, a_out_valid, a_out_ready;
    logic [7:0]  a_z;

    logic [19:0] b_i;
    logic [2:0]  b_sel;
    logic        b_in_valid, b_in_ready, b_out_valid;
    logic        b_out_ready = 1'b1;
    logic [3:0]  b_z;

    logic [1:0]  c_i;
    logic [0:0]  c_sel;
    logic        c_in_valid, c_in_ready, c_out_valid;
    logic        c_out_ready = 1'b1;
    logic [0:0]  c_z;

`ifdef MUX_TREE_PIPE_SEL_ERR_EN
    logic a_err, b_err, c_err;
`endif

    exp_t q_a[$], q_b[$], q_c[$];
    exp_t ea, eb, ec;
    bit   a_seen = 1'b0;
    int   checks = 0;
    int   failures = 0;
    bit   rand_done;

    mux_tree_pipe #(.N_IN(N8), .DW(DW8)) u_dut8 (
        .clk(clk), .rst_n(rst_n), .i(a_i), .sel(a_sel), .in_valid(a_in_valid),
        .in_ready(a_in_ready), .z(a_z), .out_valid(a_out_valid), .out_ready(a_out_ready)
`ifdef MUX_TREE_PIPE_SEL_ERR_EN
        , .err(a_err)
`endif
    );

    mux_tree_pipe #(.N_IN(N5), .DW(DW5)) u_dut5 (
        .clk(clk), .rst_n(rst_n), .i(b_i), .sel(b_sel), .in_valid(b_in_valid),
        .in_ready(b_in_ready), .z(b_z), .out_valid(b_out_valid), .out_ready(b_out_ready)
`ifdef MUX_TREE_PIPE_SEL_ERR_EN
        , .err(b_err)
`endif
    );

    mux_tree_pipe #(.N_IN(N2), .DW(DW2)) u_dut2 (
        .clk(clk), .rst_n(rst_n), .i(c_i), .sel(c_sel), .in_valid(c_in_valid),
        .in_ready(c_in_ready), .z(c_z), .out_valid(c_out_valid), .out_ready(c_out_ready)
`ifdef MUX_TREE_PIPE_SEL_ERR_EN
        , .err(c_err)
`endif
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation time limit reached, got no finish, required finish");
        $fatal(1, "watchdog");
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h at t=%0t", name, act, exp, $time);
        end
    endtask

    // Reference: channel s of a packed word vector, or 0 when s names no channel.
    function automatic logic [7:0] ref_word(input logic [63:0] data, input int s,
                                            input int n, input int dw);
        if (s >= n) return 8'h00;
        return 8'((data >> (s * dw)) & ((64'd1 << dw) - 64'd1));
    endfunction

    task automatic send_a(input logic [2:0] s, input logic [63:0] data, input bit lat);
        exp_t e;
        int   tries = 0;
        a_i = data; a_sel = s; a_in_valid = 1'b1;
        @(negedge clk);
        while (!a_in_ready && tries < 100) begin
            @(negedge clk);
            tries++;
        end
        if (!a_in_ready) begin
            check("a_send_timeout", a_in_ready, 1'b1);
        end else begin
            e.data = ref_word(data, int'(s), N8, DW8);
            e.err  = (int'(s) >= N8);
            e.acc  = cyc + 1;
            e.lat  = lat;
            q_a.push_back(e);
        end
        @(posedge clk); #1;
    endtask

    task automatic idle_a(input int n);
        a_in_valid = 1'b0;
        a_sel = 3'($urandom);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic send_b(input logic [2:0] s, input logic [19:0] data);
        exp_t e;
        b_i = data; b_sel = s; b_in_valid = 1'b1;
        @(negedge clk);
        check("b_in_ready", b_in_ready, 1'b1);
        e.data = ref_word(64'(data), int'(s), N5, DW5);
        e.err  = (int'(s) >= N5);
        e.acc  = cyc + 1;
        e.lat  = 1'b1;
        q_b.push_back(e);
        @(posedge clk); #1;
        b_in_valid = 1'b0;
    endtask

    task automatic send_c(input logic [0:0] s, input logic [1:0] data);
        exp_t e;
        c_i = data; c_sel = s; c_in_valid = 1'b1;
        @(negedge clk);
        check("c_in_ready", c_in_ready, 1'b1);
        e.data = ref_word(64'(data), int'(s), N2, DW2);
        e.err  = 1'b0;
        e.acc  = cyc + 1;
        e.lat  = 1'b1;
        q_c.push_back(e);
        @(posedge clk); #1;
        c_in_valid = 1'b0;
    endtask

    // Monitor for the 8-channel instance: compares the head of the queue while presented.
    always @(negedge clk) begin
        if (rst_n) begin
            check("a_in_ready", a_in_ready, !(a_out_valid && !a_out_ready));
            if (!a_out_valid) begin
                check("a_z_idle", a_z, 8'h00);
`ifdef MUX_TREE_PIPE_SEL_ERR_EN
                check("a_err_idle", a_err, 1'b0);
`endif
            end else if (q_a.size() == 0) begin
                check("a_spurious_valid", a_out_valid, 1'b0);
            end else begin
                ea = q_a[0];
                check("a_z", a_z, ea.data);
`ifdef MUX_TREE_PIPE_SEL_ERR_EN
                check("a_err", a_err, ea.err);
`endif
                if (ea.lat && !a_seen) check("a_latency", cyc - ea.acc, LV8 - 1);
                a_seen = 1'b1;
                if (a_out_ready) begin
                    void'(q_a.pop_front());
                    a_seen = 1'b0;
                end
            end
        end
    end

    always @(negedge clk) begin
        if (rst_n) begin
            if (!b_out_valid) begin
                check("b_z_idle", b_z, 4'h0);
`ifdef MUX_TREE_PIPE_SEL_ERR_EN
                check("b_err_idle", b_err, 1'b0);
`endif
            end else if (q_b.size() == 0) begin
                check("b_spurious_valid", b_out_valid, 1'b0);
            end else begin
                eb = q_b.pop_front();
                check("b_z", b_z, eb.data);
`ifdef MUX_TREE_PIPE_SEL_ERR_EN
                check("b_err", b_err, eb.err);
`endif
                check("b_latency", cyc - eb.acc, LV5 - 1);
            end
        end
    end

    always @(negedge clk) begin
        if (rst_n) begin
            if (!c_out_valid) begin
                check("c_z_idle", c_z, 1'b0);
            end else if (q_c.size() == 0) begin
                check("c_spurious_valid", c_out_valid, 1'b0);
            end else begin
                ec = q_c.pop_front();
                check("c_z", c_z, ec.data);
                check("c_latency", cyc - ec.acc, LV2 - 1);
            end
        end
    end

    initial begin
        logic [63:0] sweep;
        int          n;

        for (int k = 0; k < N8; k++) sweep[k*8 +: 8] = 8'hA0 + 8'(k);
        rst_n = 1'b0;
        a_i = '0; a_sel = '0; a_in_valid = 1'b0; a_out_ready = 1'b1;
        b_i = '0; b_sel = '0; b_in_valid = 1'b0;
        c_i = '0; c_sel = '0; c_in_valid = 1'b0;

        // Reset state, sampled before any clock edge.
        #3;
        check("rst_a_out_valid", a_out_valid, 1'b0);
        check("rst_a_z", a_z, 8'h00);
        check("rst_a_in_ready", a_in_ready, 1'b1);
        check("rst_b_out_valid", b_out_valid, 1'b0);
        check("rst_c_out_valid", c_out_valid, 1'b0);
`ifdef MUX_TREE_PIPE_SEL_ERR_EN
        check("rst_a_err", a_err, 1'b0);
`endif
        repeat (2) @(posedge clk);
        #1 rst_n = 1'b1;

        // Back-to-back sweep: A0..A7 in order, fixed latency, no gaps.
        for (int s = 0; s < N8; s++) send_a(3'(s), sweep, 1'b1);
        idle_a(6);

        // Mid-stream stall of five cycles.
        fork
            begin
                for (int k = 0; k < 12; k++) send_a(3'(k % N8), sweep, 1'b0);
                idle_a(1);
            end
            begin
                repeat (4) @(posedge clk);
                #1 a_out_ready = 1'b0;
                repeat (5) begin
                    @(negedge clk);
                    check("stall_out_valid", a_out_valid, 1'b1);
                    check("stall_in_ready", a_in_ready, 1'b0);
                end
                @(posedge clk);
                #1 a_out_ready = 1'b1;
            end
        join
        idle_a(8);

        // Bubbles between transactions.
        send_a(3'd1, sweep, 1'b1);
        idle_a(1);
        send_a(3'd2, sweep, 1'b1);
        idle_a(6);

        // Random traffic with random backpressure.
        rand_done = 1'b0;
        fork
            begin
                repeat (150) begin
                    send_a(3'($urandom), {$urandom, $urandom}, 1'b0);
                    if ($urandom_range(0, 3) == 0) idle_a(1);
                end
                idle_a(1);
                rand_done = 1'b1;
            end
            begin
                while (!rand_done) begin
                    @(posedge clk);
                    #1 a_out_ready = ($urandom_range(0, 3) != 0);
                end
                a_out_ready = 1'b1;
            end
        join
        idle_a(10);

        // Asynchronous reset with three transactions in flight.
        for (int k = 0; k < 3; k++) send_a(3'(k + 4), sweep, 1'b0);
        #2 rst_n = 1'b0;
        #1;
        check("arst_out_valid", a_out_valid, 1'b0);
        check("arst_z", a_z, 8'h00);
        check("arst_in_ready", a_in_ready, 1'b1);
`ifdef MUX_TREE_PIPE_SEL_ERR_EN
        check("arst_err", a_err, 1'b0);
`endif
        q_a.delete();
        a_seen = 1'b0;
        @(posedge clk);
        #1 rst_n = 1'b1;
        idle_a(8);
        send_a(3'd5, sweep, 1'b1);
        idle_a(6);

        // Non-power-of-two instance: every select value, including out-of-range ones.
        for (int s = 0; s < 8; s++) send_b(3'(s), 20'h54321);
        repeat (40) send_b(3'($urandom), 20'($urandom));

        // Two-channel instance.
        send_c(1'b1, 2'b10);
        send_c(1'b0, 2'b10);
        repeat (20) send_c(1'($urandom), 2'($urandom));

        n = 0;
        while ((q_a.size() != 0 || q_b.size() != 0 || q_c.size() != 0) && n < 100) begin
            @(posedge clk);
            n++;
        end
        #1;
        check("drain_a", q_a.size(), 0);
        check("drain_b", q_b.size(), 0);
        check("drain_c", q_c.size(), 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
